// File: rtl/ptw_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ptw_mem_arbiter
//
// Purpose: shares one memory read port between the IFU MMU page-table walker
// (port I) and the LSU MMU page-table walker (port D). Round-robin grant with
// a single outstanding read. Responses go back only to the owner of the
// outstanding read, and are dropped if the walk was cancelled by a flush or by
// the owner withdrawing its request.
//
// Optional feature macro: PTW_ARB_TIMEOUT_EN
//   defined   : a WAIT-cycle counter reports a timeout after TIMEOUT_CYC cycles
//               (rvalid with rdata=0 and ptw_err_o=1), then the arbiter drains
//               the late response before accepting new grants.
//   undefined : WAIT waits indefinitely and ptw_err_o is tied to 0.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_mem_req_i/addr_i         IFU walker request (level) and PTE address
//   i_mem_rdata_o/rvalid_o     IFU walker PTE data and 1-cycle valid pulse
//   d_mem_req_i/addr_i         LSU walker request (level) and PTE address
//   d_mem_rdata_o/rvalid_o     LSU walker PTE data and 1-cycle valid pulse
//   mem_req_valid_o/ready_i    request handshake to the memory port
//   mem_req_addr_o             request address
//   mem_resp_valid_i/data_i    read response from the memory port
//   mmu_flush_i                cancels any in-flight walk, blocks new grants
//   ptw_err_o                  timeout error pulse, coincident with rvalid
// ---------------------------------------------------------------------------
module ptw_mem_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_mem_req_i,
   input  logic [AW-1:0] i_mem_addr_i,
   output logic [DW-1:0] i_mem_rdata_o,
   output logic          i_mem_rvalid_o,
   input  logic          d_mem_req_i,
   input  logic [AW-1:0] d_mem_addr_i,
   output logic [DW-1:0] d_mem_rdata_o,
   output logic          d_mem_rvalid_o,
   output logic          mem_req_valid_o,
   input  logic          mem_req_ready_i,
   output logic [AW-1:0] mem_req_addr_o,
   input  logic          mem_resp_valid_i,
   input  logic [DW-1:0] mem_resp_data_i,
   input  logic          mmu_flush_i,
   output logic          ptw_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          cancel_q, cancel_d;

   // response stage registers (one cycle after mem_resp_valid_i)
   logic          i_vld_p1, i_vld_d;
   logic          d_vld_p1, d_vld_d;
   logic [DW-1:0] i_data_p1, i_data_d;
   logic [DW-1:0] d_data_p1, d_data_d;

   logic          deliver;
   logic [DW-1:0] deliver_data;
   logic          owner_req;
   logic          drop_now;
   logic          i_req_eff;
   logic          d_req_eff;

`ifdef PTW_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_p1, err_d;
   logic             deliver_err;
`endif

   assign owner_req = (owner_q == OWN_D) ? d_mem_req_i : i_mem_req_i;
   assign drop_now  = mmu_flush_i | ~owner_req;

   // A walker keeps its request high during the cycle its rvalid pulses;
   // masking it there prevents granting that stale request a second time.
   assign i_req_eff = i_mem_req_i & ~i_vld_p1;
   assign d_req_eff = d_mem_req_i & ~d_vld_p1;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      cancel_d     = cancel_q;
      deliver      = 1'b0;
      deliver_data = '0;
      i_vld_d      = 1'b0;
      d_vld_d      = 1'b0;
      i_data_d     = i_data_p1;
      d_data_d     = d_data_p1;
`ifdef PTW_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = 1'b0;
      deliver_err  = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (!mmu_flush_i && (i_req_eff || d_req_eff)) begin
               if (i_req_eff && d_req_eff) owner_d = ~last_grant_q;
               else                        owner_d = d_req_eff;
               addr_d       = (owner_d == OWN_D) ? d_mem_addr_i : i_mem_addr_i;
               last_grant_d = owner_d;
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            // valid stays up until the handshake even when cancelled
            if (drop_now) cancel_d = 1'b1;
            if (mem_req_ready_i) begin
               state_d = S_WAIT;
`ifdef PTW_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_WAIT: begin
            if (drop_now) cancel_d = 1'b1;
            if (mem_resp_valid_i) begin
               // a flush or request drop in the response cycle also discards it
               deliver      = ~(cancel_q | drop_now);
               deliver_data = mem_resp_data_i;
               state_d      = S_IDLE;
            end
`ifdef PTW_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               deliver     = ~(cancel_q | drop_now);
               deliver_err = 1'b1;
               state_d     = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_DRAIN: begin
            if (mem_resp_valid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE) cancel_d = 1'b0;

      if (deliver) begin
         if (owner_q == OWN_D) begin
            d_vld_d  = 1'b1;
            d_data_d = deliver_data;
         end else begin
            i_vld_d  = 1'b1;
            i_data_d = deliver_data;
         end
`ifdef PTW_ARB_TIMEOUT_EN
         err_d = deliver_err;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_I;
         last_grant_q <= OWN_D;
         addr_q       <= '0;
         cancel_q     <= 1'b0;
         i_vld_p1     <= 1'b0;
         d_vld_p1     <= 1'b0;
         i_data_p1    <= '0;
         d_data_p1    <= '0;
`ifdef PTW_ARB_TIMEOUT_EN
         cnt_q        <= '0;
         err_p1       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         cancel_q     <= cancel_d;
         i_vld_p1     <= i_vld_d;
         d_vld_p1     <= d_vld_d;
         i_data_p1    <= i_data_d;
         d_data_p1    <= d_data_d;
`ifdef PTW_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_p1       <= err_d;
`endif
      end
   end

   assign mem_req_valid_o = (state_q == S_REQ);
   assign mem_req_addr_o  = addr_q;
   assign i_mem_rvalid_o  = i_vld_p1;
   assign d_mem_rvalid_o  = d_vld_p1;
   assign i_mem_rdata_o   = i_data_p1;
   assign d_mem_rdata_o   = d_data_p1;

`ifdef PTW_ARB_TIMEOUT_EN
   assign ptw_err_o = err_p1;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC > 1);
   assign ptw_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ptw_mem_arbiter
//
// Per-cycle vector table (inputs applied for one clock, outputs compared just
// after that edge) covering single walks, round-robin alternation, request
// back-pressure, flush cancellation, request drop, ignored stray responses and
// reset mid-walk; followed by a hand-written long-wait sequence (timeout when
// PTW_ARB_TIMEOUT_EN is defined, no timeout otherwise).
// ---------------------------------------------------------------------------
module tb_ptw_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef PTW_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 256;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_mem_req_i, d_mem_req_i;
   logic [AW-1:0] i_mem_addr_i, d_mem_addr_i;
   logic [DW-1:0] i_mem_rdata_o, d_mem_rdata_o;
   logic          i_mem_rvalid_o, d_mem_rvalid_o;
   logic          mem_req_valid_o, mem_req_ready_i;
   logic [AW-1:0] mem_req_addr_o;
   logic          mem_resp_valid_i;
   logic [DW-1:0] mem_resp_data_i;
   logic          mmu_flush_i;
   logic          ptw_err_o;

   always #5 clk = ~clk;

   ptw_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_mem_req_i      (i_mem_req_i),
      .i_mem_addr_i     (i_mem_addr_i),
      .i_mem_rdata_o    (i_mem_rdata_o),
      .i_mem_rvalid_o   (i_mem_rvalid_o),
      .d_mem_req_i      (d_mem_req_i),
      .d_mem_addr_i     (d_mem_addr_i),
      .d_mem_rdata_o    (d_mem_rdata_o),
      .d_mem_rvalid_o   (d_mem_rvalid_o),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_resp_valid_i (mem_resp_valid_i),
      .mem_resp_data_i  (mem_resp_data_i),
      .mmu_flush_i      (mmu_flush_i),
      .ptw_err_o        (ptw_err_o)
   );

   typedef struct {
      logic        rst_n;
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic [31:0] d_addr;
      logic        ready;
      logic        rvld;
      logic [31:0] rdata;
      logic        flush;
      logic        e_mv;
      logic [31:0] e_ma;
      logic        e_ir;
      logic [31:0] e_ird;
      logic        e_dr;
      logic [31:0] e_drd;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0;
   int   n_err = 0;

   localparam logic [31:0] A1 = 32'h8000_1000, P1 = 32'h2000_0C01;
   localparam logic [31:0] IA = 32'h8000_2000, DA = 32'h9000_3000;
   localparam logic [31:0] DB = 32'h9000_4000, JA = 32'hFFFF_F000;
   localparam logic [31:0] IC = 32'h8000_5000, DC = 32'h9000_6000;
   localparam logic [31:0] DD = 32'h9000_7000, ID = 32'h8000_8000;
   localparam logic [31:0] IE = 32'h8000_9000, DE = 32'h9000_A000;
   localparam logic [31:0] IF = 32'h8000_B000, DF = 32'h9000_C000;
   localparam logic [31:0] JD = 32'hDEAD_BEEF;
   localparam logic [31:0] D1 = 32'h1111_0001, D2 = 32'h2222_0002;
   localparam logic [31:0] D3 = 32'h3333_0003, D4 = 32'h4444_0004;
   localparam logic [31:0] D5 = 32'h5555_0005, D6 = 32'h6666_0006;
   localparam logic [31:0] D7 = 32'h7777_0007, D8 = 32'h8888_0008;
   localparam logic [31:0] D9 = 32'h9999_0009, DX = 32'hAAAA_000A;
   localparam logic [31:0] DY = 32'hBBBB_000B, DZ = 32'hCCCC_000C;

   function automatic vec_t v(
      logic rs, logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
      logic rdy, logic rv, logic [31:0] rd, logic fl,
      logic emv, logic [31:0] ema, logic eir, logic [31:0] eird,
      logic edr, logic [31:0] edrd);
      vec_t r;
      r.rst_n = rs;  r.i_req = ir;  r.i_addr = ia;  r.d_req = dr;  r.d_addr = da;
      r.ready = rdy; r.rvld = rv;   r.rdata = rd;   r.flush = fl;
      r.e_mv = emv;  r.e_ma = ema;  r.e_ir = eir;   r.e_ird = eird;
      r.e_dr = edr;  r.e_drd = edrd;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rs, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da, input logic rdy,
                        input logic rv, input logic [31:0] rd, input logic fl);
      rst_n = rs; i_mem_req_i = ir; i_mem_addr_i = ia; d_mem_req_i = dr;
      d_mem_addr_i = da; mem_req_ready_i = rdy; mem_resp_valid_i = rv;
      mem_resp_data_i = rd; mmu_flush_i = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int bad;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // reset state
      tbl.push_back(v(0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
      // single I walk, response 3 cycles after the handshake
      tbl.push_back(v(1,1,A1,0,0,1,0,0,0,   1,A1,0,0,0,0));
      tbl.push_back(v(1,1,A1,0,0,1,0,0,0,   0,A1,0,0,0,0));
      tbl.push_back(v(1,1,A1,0,0,1,0,0,0,   0,A1,0,0,0,0));
      tbl.push_back(v(1,1,A1,0,0,1,0,0,0,   0,A1,0,0,0,0));
      tbl.push_back(v(1,1,A1,0,0,1,1,P1,0,  0,A1,1,P1,0,0));
      tbl.push_back(v(1,0,A1,0,0,1,0,0,0,   0,A1,0,P1,0,0));
      // reset, then both walkers request continuously: I, D, I, D
      tbl.push_back(v(0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
      tbl.push_back(v(1,1,IA,1,DA,1,0,0,0,  1,IA,0,0,0,0));
      tbl.push_back(v(1,1,IA,1,DA,1,0,0,0,  0,IA,0,0,0,0));
      tbl.push_back(v(1,1,IA,1,DA,1,1,D1,0, 0,IA,1,D1,0,0));
      tbl.push_back(v(1,1,IA,1,DA,1,0,0,0,  1,DA,0,D1,0,0));
      tbl.push_back(v(1,1,IA,1,DA,1,0,0,0,  0,DA,0,D1,0,0));
      tbl.push_back(v(1,1,IA,1,DA,1,1,D2,0, 0,DA,0,D1,1,D2));
      tbl.push_back(v(1,1,IA,1,DA,1,0,0,0,  1,IA,0,D1,0,D2));
      tbl.push_back(v(1,1,IA,1,DA,1,0,0,0,  0,IA,0,D1,0,D2));
      tbl.push_back(v(1,1,IA,1,DA,1,1,D3,0, 0,IA,1,D3,0,D2));
      tbl.push_back(v(1,1,IA,1,DA,1,0,0,0,  1,DA,0,D3,0,D2));
      tbl.push_back(v(1,1,IA,1,DA,1,0,0,0,  0,DA,0,D3,0,D2));
      tbl.push_back(v(1,0,0,1,DA,1,1,D4,0,  0,DA,0,D3,1,D4));
      tbl.push_back(v(1,0,0,0,0,1,0,0,0,    0,DA,0,D3,0,D4));
      // ready low for 5 cycles: valid and address held despite input address change
      tbl.push_back(v(1,0,0,1,DB,0,0,0,0,   1,DB,0,D3,0,D4));
      for (int k = 0; k < 5; k++)
         tbl.push_back(v(1,0,0,1,JA,0,0,0,0, 1,DB,0,D3,0,D4));
      tbl.push_back(v(1,0,0,1,DB,1,0,0,0,   0,DB,0,D3,0,D4));
      tbl.push_back(v(1,0,0,1,DB,1,1,D5,0,  0,DB,0,D3,1,D5));
      tbl.push_back(v(1,0,0,0,0,1,0,0,0,    0,DB,0,D3,0,D5));
      // flush during WAIT: late response discarded, then D granted normally
      tbl.push_back(v(1,1,IC,0,0,1,0,0,0,   1,IC,0,D3,0,D5));
      tbl.push_back(v(1,1,IC,0,0,1,0,0,0,   0,IC,0,D3,0,D5));
      tbl.push_back(v(1,0,0,0,0,1,0,0,1,    0,IC,0,D3,0,D5));
      tbl.push_back(v(1,0,0,1,DC,1,0,0,0,   0,IC,0,D3,0,D5));
      tbl.push_back(v(1,0,0,1,DC,1,1,JD,0,  0,IC,0,D3,0,D5));
      tbl.push_back(v(1,0,0,1,DC,1,0,0,0,   1,DC,0,D3,0,D5));
      tbl.push_back(v(1,0,0,1,DC,1,0,0,0,   0,DC,0,D3,0,D5));
      tbl.push_back(v(1,0,0,1,DC,1,1,D6,0,  0,DC,0,D3,1,D6));
      tbl.push_back(v(1,0,0,0,0,1,0,0,0,    0,DC,0,D3,0,D6));
      // D drops its request in REQ: bus request completes, response discarded
      tbl.push_back(v(1,0,0,1,DD,0,0,0,0,   1,DD,0,D3,0,D6));
      tbl.push_back(v(1,0,0,0,0,0,0,0,0,    1,DD,0,D3,0,D6));
      tbl.push_back(v(1,0,0,0,0,1,0,0,0,    0,DD,0,D3,0,D6));
      tbl.push_back(v(1,0,0,0,0,1,1,D7,0,   0,DD,0,D3,0,D6));
      tbl.push_back(v(1,0,0,0,0,1,0,0,0,    0,DD,0,D3,0,D6));
      tbl.push_back(v(1,1,ID,0,0,1,0,0,0,   1,ID,0,D3,0,D6));
      tbl.push_back(v(1,1,ID,0,0,1,0,0,0,   0,ID,0,D3,0,D6));
      tbl.push_back(v(1,1,ID,0,0,1,1,D8,0,  0,ID,1,D8,0,D6));
      // stray response while idle is ignored
      tbl.push_back(v(1,0,0,0,0,1,1,JD,0,   0,ID,0,D8,0,D6));
      // flush coincident with response; flush in IDLE blocks the grant
      tbl.push_back(v(1,1,IE,0,0,1,0,0,0,   1,IE,0,D8,0,D6));
      tbl.push_back(v(1,1,IE,0,0,1,0,0,0,   0,IE,0,D8,0,D6));
      tbl.push_back(v(1,1,IE,0,0,1,1,JD,1,  0,IE,0,D8,0,D6));
      tbl.push_back(v(1,0,0,0,0,1,0,0,0,    0,IE,0,D8,0,D6));
      tbl.push_back(v(1,1,IE,0,0,1,0,0,1,   0,IE,0,D8,0,D6));
      tbl.push_back(v(1,1,IE,0,0,1,0,0,0,   1,IE,0,D8,0,D6));
      tbl.push_back(v(1,1,IE,0,0,1,0,0,0,   0,IE,0,D8,0,D6));
      tbl.push_back(v(1,1,IE,0,0,1,1,D9,0,  0,IE,1,D9,0,D6));
      tbl.push_back(v(1,0,0,0,0,1,0,0,0,    0,IE,0,D9,0,D6));
      // reset in the middle of a walk
      tbl.push_back(v(1,0,0,1,DE,1,0,0,0,   1,DE,0,D9,0,D6));
      tbl.push_back(v(0,0,0,1,DE,1,0,0,0,   0,0,0,0,0,0));
      tbl.push_back(v(1,0,0,1,DE,1,0,0,0,   1,DE,0,0,0,0));
      tbl.push_back(v(1,0,0,1,DE,1,0,0,0,   0,DE,0,0,0,0));
      tbl.push_back(v(1,0,0,1,DE,1,1,DX,0,  0,DE,0,0,1,DX));
      tbl.push_back(v(1,0,0,0,0,1,0,0,0,    0,DE,0,0,0,DX));

      foreach (tbl[n]) begin
         drive(tbl[n].rst_n, tbl[n].i_req, tbl[n].i_addr, tbl[n].d_req, tbl[n].d_addr,
               tbl[n].ready, tbl[n].rvld, tbl[n].rdata, tbl[n].flush);
         step();
         chk($sformatf("row%0d.mem_valid", n), 32'(mem_req_valid_o), 32'(tbl[n].e_mv));
         chk($sformatf("row%0d.mem_addr",  n), mem_req_addr_o,        tbl[n].e_ma);
         chk($sformatf("row%0d.i_rvalid",  n), 32'(i_mem_rvalid_o),  32'(tbl[n].e_ir));
         chk($sformatf("row%0d.i_rdata",   n), i_mem_rdata_o,         tbl[n].e_ird);
         chk($sformatf("row%0d.d_rvalid",  n), 32'(d_mem_rvalid_o),  32'(tbl[n].e_dr));
         chk($sformatf("row%0d.d_rdata",   n), d_mem_rdata_o,         tbl[n].e_drd);
         chk($sformatf("row%0d.ptw_err",   n), 32'(ptw_err_o),        32'd0);
      end

      // long wait for a response: start an I walk
      drive(1, 1, IF, 0, 0, 1, 0, 0, 0);
      step();
      chk("long.grant_valid", 32'(mem_req_valid_o), 32'd1);
      chk("long.grant_addr",  mem_req_addr_o, IF);
      step();
      chk("long.handshake", 32'(mem_req_valid_o), 32'd0);
`ifdef PTW_ARB_TIMEOUT_EN
      bad = 0;
      for (int k = 0; k < TO - 1; k++) begin
         step();
         if (i_mem_rvalid_o || d_mem_rvalid_o || ptw_err_o) bad++;
      end
      chk("to.early_pulses", 32'(bad), 32'd0);
      step();
      chk("to.i_rvalid", 32'(i_mem_rvalid_o), 32'd1);
      chk("to.i_rdata",  i_mem_rdata_o, 32'd0);
      chk("to.err",      32'(ptw_err_o), 32'd1);
      chk("to.d_rvalid", 32'(d_mem_rvalid_o), 32'd0);
      drive(1, 0, 0, 1, DF, 1, 0, 0, 0);
      step();
      chk("drain.i_rvalid", 32'(i_mem_rvalid_o), 32'd0);
      chk("drain.err",      32'(ptw_err_o), 32'd0);
      step();
      chk("drain.no_grant", 32'(mem_req_valid_o), 32'd0);
      drive(1, 0, 0, 1, DF, 1, 1, JD, 0);
      step();
      chk("drain.swallow_d", 32'(d_mem_rvalid_o), 32'd0);
      chk("drain.swallow_i", 32'(i_mem_rvalid_o), 32'd0);
      chk("drain.still_no_grant", 32'(mem_req_valid_o), 32'd0);
      drive(1, 0, 0, 1, DF, 1, 0, 0, 0);
      step();
      chk("post.grant_valid", 32'(mem_req_valid_o), 32'd1);
      chk("post.grant_addr",  mem_req_addr_o, DF);
      step();
      drive(1, 0, 0, 1, DF, 1, 1, DZ, 0);
      step();
      chk("post.d_rvalid", 32'(d_mem_rvalid_o), 32'd1);
      chk("post.d_rdata",  d_mem_rdata_o, DZ);
      chk("post.err",      32'(ptw_err_o), 32'd0);
`else
      bad = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (i_mem_rvalid_o || d_mem_rvalid_o || ptw_err_o || mem_req_valid_o) bad++;
      end
      chk("wait.no_timeout", 32'(bad), 32'd0);
      drive(1, 1, IF, 0, 0, 1, 1, DY, 0);
      step();
      chk("wait.i_rvalid", 32'(i_mem_rvalid_o), 32'd1);
      chk("wait.i_rdata",  i_mem_rdata_o, DY);
      chk("wait.err",      32'(ptw_err_o), 32'd0);
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
      step();
      chk("wait.pulse_end", 32'(i_mem_rvalid_o), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
